// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg
// Shared CPU types: register index type, pipeline-controller state enum,
// performance-counter type and its saturating increment.
package cpu_types_pkg;

  localparam int REG_W = 5;
  localparam int CNT_W = 16;

  typedef logic [REG_W-1:0] regbits_t;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } pctrl_state_t;

  // Counters stick at all-ones instead of wrapping.
  function automatic cnt_t sat_inc(cnt_t v);
    return (v == '1) ? v : v + cnt_t'(1);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// hazard_detect
// Combinational load-use detector: flags when the load in ID/EX writes a
// register that the instruction in IF/ID reads.
// Ports:
//   idex_memread - ID/EX holds a load
//   idex_rt      - load destination register
//   ifid_rs/rt   - source registers of the instruction in ID
//   load_use     - hazard flag
module hazard_detect
  import cpu_types_pkg::*;
(
  input  logic     idex_memread,
  input  regbits_t idex_rt,
  input  regbits_t ifid_rs,
  input  regbits_t ifid_rt,
  output logic     load_use
);

  // r0 is hardwired zero, so a load targeting it never creates a dependency.
  assign load_use = idex_memread && (idex_rt != '0) &&
                    ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
// Stall/flush/halt controller for a 5-stage pipeline. Drives PC enable and
// en/flush/freeze for the IF/ID, ID/EX, EX/MEM and MEM/WB latches, tracks the
// halt drain sequence and keeps saturating stall/flush counters.
// Ports:
//   CLK, RST            - clock, synchronous active-high reset
//   ihit, dhit          - fetch valid, data access complete
//   mem_ren, mem_wen    - MEM-stage data request
//   ex_pcsrc            - taken branch/jump resolved in EX
//   idex_memread, idex_rt, ifid_rs, ifid_rt - load-use inputs
//   id_halt, wb_halt    - halt in ID, halt at MEM/WB output
//   pc_en, *_en/_flush/_freeze - pipeline control (Mealy)
//   halt                - processor halted
//   stall_cnt, flush_cnt - saturating performance counters
//
// state  | meaning
// RUN    | normal operation, hazard priority dwait > branch > load-use > imiss
// DRAIN  | halt passed ID; fetch stopped, older instructions retire
// HALTED | halt retired; everything frozen until reset
module pipeline_ctrl
  import cpu_types_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic        ex_pcsrc,
  input  logic        idex_memread,
  input  regbits_t    idex_rt,
  input  regbits_t    ifid_rs,
  input  regbits_t    ifid_rt,
  input  logic        id_halt,
  input  logic        wb_halt,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        ifid_freeze,
  output logic        idex_en,
  output logic        idex_flush,
  output logic        idex_freeze,
  output logic        exmem_en,
  output logic        exmem_flush,
  output logic        exmem_freeze,
  output logic        memwb_en,
  output logic        memwb_flush,
  output logic        memwb_freeze,
  output logic        halt,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  pctrl_state_t state;
  logic         load_use;
  logic         dwait;
  logic         flush_evt;
  logic         id_advance;

  hazard_detect u_hazard (
    .idex_memread (idex_memread),
    .idex_rt      (idex_rt),
    .ifid_rs      (ifid_rs),
    .ifid_rt      (ifid_rt),
    .load_use     (load_use)
  );

  assign dwait      = (mem_ren || mem_wen) && !dhit;
  // Branches are ignored once draining: the halt is already past EX's reach.
  assign flush_evt  = (state == RUN) && !dwait && ex_pcsrc;
  // The ID instruction moves into ID/EX only in the imiss/normal cases.
  assign id_advance = !dwait && !ex_pcsrc && !load_use;

  always_comb begin
    pc_en        = 1'b0;
    ifid_en      = 1'b0;
    ifid_flush   = 1'b0;
    ifid_freeze  = 1'b0;
    idex_en      = 1'b0;
    idex_flush   = 1'b0;
    idex_freeze  = 1'b0;
    exmem_en     = 1'b0;
    exmem_flush  = 1'b0;
    exmem_freeze = 1'b0;
    memwb_en     = 1'b0;
    memwb_flush  = 1'b0;
    memwb_freeze = 1'b0;
    halt         = 1'b0;
    if (RST) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
    end else if (state == HALTED) begin
      ifid_freeze  = 1'b1;
      idex_freeze  = 1'b1;
      exmem_freeze = 1'b1;
      memwb_freeze = 1'b1;
      halt         = 1'b1;
    end else begin
      if (dwait) begin
        ifid_freeze  = 1'b1;
        idex_freeze  = 1'b1;
        exmem_freeze = 1'b1;
        memwb_freeze = 1'b1;
      end else if (flush_evt) begin
        pc_en      = 1'b1;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
      end else if (load_use) begin
        ifid_freeze = 1'b1;
        idex_flush  = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
      end else if (!ihit) begin
        ifid_flush = 1'b1;
        idex_en    = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
      end else begin
        pc_en    = 1'b1;
        ifid_en  = 1'b1;
        idex_en  = 1'b1;
        exmem_en = 1'b1;
        memwb_en = 1'b1;
      end
      // While draining, fetch is stopped and IF/ID only ever holds bubbles.
      if (state == DRAIN) begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        ifid_freeze = 1'b0;
        ifid_flush  = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= RUN;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      case (state)
        RUN:     if (id_halt && id_advance) state <= DRAIN;
        DRAIN:   if (wb_halt && !dwait) state <= HALTED;
        HALTED:  state <= HALTED;
        default: state <= RUN;
      endcase
      if ((state != HALTED) && !pc_en) stall_cnt <= sat_inc(stall_cnt);
      if (flush_evt) flush_cnt <= sat_inc(flush_cnt);
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

  logic        CLK = 1'b0;
  logic        RST, ihit, dhit, mem_ren, mem_wen, ex_pcsrc, idex_memread;
  logic [4:0]  idex_rt, ifid_rs, ifid_rt;
  logic        id_halt, wb_halt;
  logic        pc_en, halt;
  logic        ifid_en, ifid_flush, ifid_freeze, idex_en, idex_flush, idex_freeze;
  logic        exmem_en, exmem_flush, exmem_freeze, memwb_en, memwb_flush, memwb_freeze;
  logic [15:0] stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  pipeline_ctrl dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .mem_ren(mem_ren), .mem_wen(mem_wen),
    .ex_pcsrc(ex_pcsrc), .idex_memread(idex_memread), .idex_rt(idex_rt),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .id_halt(id_halt), .wb_halt(wb_halt),
    .pc_en(pc_en),
    .ifid_en(ifid_en), .ifid_flush(ifid_flush), .ifid_freeze(ifid_freeze),
    .idex_en(idex_en), .idex_flush(idex_flush), .idex_freeze(idex_freeze),
    .exmem_en(exmem_en), .exmem_flush(exmem_flush), .exmem_freeze(exmem_freeze),
    .memwb_en(memwb_en), .memwb_flush(memwb_flush), .memwb_freeze(memwb_freeze),
    .halt(halt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  typedef struct packed {
    logic rst, ihit, dhit, ren, wen, pcsrc, memread;
    logic [4:0] rt, rs, rt2;
    logic idh, wbh;
  } in_t;

  // latch vectors: [3]=ifid [2]=idex [1]=exmem [0]=memwb
  typedef struct packed {
    logic       pc;
    logic [3:0] en, fl, fr;
    logic       halt;
  } out_t;

  typedef struct {
    in_t   i;
    out_t  o;
    string name;
  } vec_t;

  typedef enum logic [1:0] {ADV, BUB, HLD} act_t;

  localparam int M_RUN = 0, M_DRAIN = 1, M_HALT = 2;

  function automatic in_t mk(input logic r, ih, dh, rn, wn, pc, mr,
                             input logic [4:0] rt, rs, rt2);
    return in_t'({r, ih, dh, rn, wn, pc, mr, rt, rs, rt2, 1'b0, 1'b0});
  endfunction

  function automatic out_t mo(input logic pc, input logic [3:0] en, fl, fr, input logic h);
    return out_t'({pc, en, fl, fr, h});
  endfunction

  function automatic out_t dut_out();
    return out_t'({pc_en, {ifid_en, idex_en, exmem_en, memwb_en},
                   {ifid_flush, idex_flush, exmem_flush, memwb_flush},
                   {ifid_freeze, idex_freeze, exmem_freeze, memwb_freeze}, halt});
  endfunction

  // Reference: each latch gets an action (advance / bubble / hold) from the
  // hazard that wins in the current mode.
  function automatic out_t model_out(input in_t i, input int mode);
    act_t a[4];
    logic pc = 1'b0;
    logic h  = 1'b0;
    logic dw, lu, br;
    out_t o;
    dw = (i.ren | i.wen) & ~i.dhit;
    lu = i.memread && (i.rt != 0) && ((i.rt == i.rs) || (i.rt == i.rt2));
    br = i.pcsrc && (mode == M_RUN);
    if (i.rst) a = '{BUB, BUB, BUB, BUB};
    else if (mode == M_HALT) begin
      a = '{HLD, HLD, HLD, HLD};
      h = 1'b1;
    end else begin
      if (dw) a = '{HLD, HLD, HLD, HLD};
      else if (br) begin a = '{BUB, BUB, ADV, ADV}; pc = 1'b1; end
      else if (lu) a = '{HLD, BUB, ADV, ADV};
      else if (!i.ihit) a = '{BUB, ADV, ADV, ADV};
      else begin a = '{ADV, ADV, ADV, ADV}; pc = 1'b1; end
      if (mode == M_DRAIN) begin a[0] = BUB; pc = 1'b0; end
    end
    o.pc = pc;
    o.halt = h;
    for (int k = 0; k < 4; k++) begin
      o.en[3-k] = (a[k] == ADV);
      o.fl[3-k] = (a[k] == BUB);
      o.fr[3-k] = (a[k] == HLD);
    end
    return o;
  endfunction

  task automatic drive(input in_t v);
    RST = v.rst; ihit = v.ihit; dhit = v.dhit; mem_ren = v.ren; mem_wen = v.wen;
    ex_pcsrc = v.pcsrc; idex_memread = v.memread; idex_rt = v.rt; ifid_rs = v.rs;
    ifid_rt = v.rt2; id_halt = v.idh; wb_halt = v.wbh;
  endtask

  task automatic check_out(input string nm, input out_t exp);
    out_t got;
    got = dut_out();
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got pc/en/fl/fr/halt=%b required %b", nm, got, exp);
    end
  endtask

  task automatic check_val(input string nm, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", nm, got, exp);
    end
  endtask

  // Exclusivity on every cycle, sampled mid-cycle.
  task automatic half();
    out_t g;
    logic bad;
    @(negedge CLK);
    g = dut_out();
    bad = 1'b0;
    for (int k = 0; k < 4; k++)
      if ((g.en[k] && g.fr[k]) || (g.fl[k] && (g.en[k] || g.fr[k]))) bad = 1'b1;
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL exclusivity: got en=%b fl=%b fr=%b required exclusive", g.en, g.fl, g.fr);
    end
  endtask

  task automatic edge_();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    drive(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    half();
    edge_();
  endtask

  vec_t tbl[$];
  in_t  idle, v;
  out_t exp;
  int   mode, ms, mf;
  logic dw;

  initial begin
    idle = mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl.push_back('{mk(1,1,1,0,0,0,0,0,0,0),  mo(1'b0,4'b0000,4'b1111,4'b0000,1'b0), "reset_out"});
    tbl.push_back('{mk(0,1,1,0,0,0,0,0,0,0),  mo(1'b1,4'b1111,4'b0000,4'b0000,1'b0), "normal"});
    tbl.push_back('{mk(0,1,1,1,0,0,0,0,0,0),  mo(1'b1,4'b1111,4'b0000,4'b0000,1'b0), "read_hit"});
    tbl.push_back('{mk(0,1,0,1,0,0,0,0,0,0),  mo(1'b0,4'b0000,4'b0000,4'b1111,1'b0), "dwait_rd"});
    tbl.push_back('{mk(0,0,0,0,1,0,0,0,0,0),  mo(1'b0,4'b0000,4'b0000,4'b1111,1'b0), "dwait_wr"});
    tbl.push_back('{mk(0,1,1,0,0,1,0,0,0,0),  mo(1'b1,4'b0011,4'b1100,4'b0000,1'b0), "branch"});
    tbl.push_back('{mk(0,0,1,0,0,1,1,5,5,0),  mo(1'b1,4'b0011,4'b1100,4'b0000,1'b0), "branch_over_lu"});
    tbl.push_back('{mk(0,1,1,0,0,0,1,7,7,1),  mo(1'b0,4'b0011,4'b0100,4'b1000,1'b0), "lu_rs"});
    tbl.push_back('{mk(0,1,1,0,0,0,1,31,2,31),mo(1'b0,4'b0011,4'b0100,4'b1000,1'b0), "lu_rt"});
    tbl.push_back('{mk(0,1,1,0,0,0,1,0,0,0),  mo(1'b1,4'b1111,4'b0000,4'b0000,1'b0), "lu_r0"});
    tbl.push_back('{mk(0,1,1,0,0,0,1,3,4,5),  mo(1'b1,4'b1111,4'b0000,4'b0000,1'b0), "lu_nomatch"});
    tbl.push_back('{mk(0,0,1,0,0,0,1,9,9,9),  mo(1'b0,4'b0011,4'b0100,4'b1000,1'b0), "lu_over_imiss"});
    tbl.push_back('{mk(0,0,1,0,0,0,0,0,0,0),  mo(1'b0,4'b0111,4'b1000,4'b0000,1'b0), "imiss"});
    tbl.push_back('{mk(0,1,1,0,0,0,0,6,6,6),  mo(1'b1,4'b1111,4'b0000,4'b0000,1'b0), "no_load"});
    tbl.push_back('{mk(0,1,0,1,0,1,1,5,5,5),  mo(1'b0,4'b0000,4'b0000,4'b1111,1'b0), "dwait_over_br"});

    do_reset();
    check_val("rst_stall", stall_cnt, 16'd0);
    check_val("rst_flush", flush_cnt, 16'd0);
    foreach (tbl[n]) begin
      drive(tbl[n].i);
      half();
      check_out(tbl[n].name, tbl[n].o);
      edge_();
    end

    // load-use then the same with r0 as destination
    do_reset();
    drive(mk(0, 1, 1, 0, 0, 0, 1, 5, 5, 0));
    half();
    check_out("lu_seq", mo(1'b0, 4'b0011, 4'b0100, 4'b1000, 1'b0));
    edge_();
    check_val("lu_stall", stall_cnt, 16'd1);
    drive(mk(0, 1, 1, 0, 0, 0, 1, 0, 0, 0));
    half();
    check_out("lu_r0_seq", mo(1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b0));
    edge_();
    check_val("lu_r0_stall", stall_cnt, 16'd1);

    // dwait masks a pending branch for 3 cycles
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(mk(0, 1, 0, 1, 0, 1, 0, 0, 0, 0));
      half();
      check_out("dwait_br_freeze", mo(1'b0, 4'b0000, 4'b0000, 4'b1111, 1'b0));
      edge_();
    end
    check_val("dwait_br_flushcnt", flush_cnt, 16'd0);
    check_val("dwait_br_stallcnt", stall_cnt, 16'd3);
    drive(mk(0, 1, 1, 1, 0, 1, 0, 0, 0, 0));
    half();
    check_out("dwait_br_release", mo(1'b1, 4'b0011, 4'b1100, 4'b0000, 1'b0));
    edge_();
    check_val("dwait_br_flushcnt2", flush_cnt, 16'd1);
    check_val("dwait_br_stallcnt2", stall_cnt, 16'd3);

    // halt sequence, with a branch during drain that must be ignored
    do_reset();
    v = idle; v.idh = 1'b1;
    drive(v);
    half();
    check_out("halt_enter", mo(1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b0));
    edge_();
    for (int k = 0; k < 3; k++) begin
      v = idle; v.pcsrc = (k == 0); v.wbh = (k == 2);
      drive(v);
      half();
      check_out("drain", mo(1'b0, 4'b0111, 4'b1000, 4'b0000, 1'b0));
      edge_();
    end
    for (int k = 0; k < 10; k++) begin
      v = idle; v.pcsrc = k[0]; v.ihit = k[1];
      drive(v);
      half();
      check_out("halted", mo(1'b0, 4'b0000, 4'b0000, 4'b1111, 1'b1));
      edge_();
    end
    check_val("halted_stall", stall_cnt, 16'd3);
    check_val("halted_flush", flush_cnt, 16'd0);

    // reset in the middle of drain
    do_reset();
    v = idle; v.idh = 1'b1;
    drive(v);
    half();
    edge_();
    drive(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    half();
    check_out("rst_in_drain", mo(1'b0, 4'b0000, 4'b1111, 4'b0000, 1'b0));
    edge_();
    drive(idle);
    half();
    check_out("after_rst_drain", mo(1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b0));
    check_val("after_rst_stall", stall_cnt, 16'd0);
    check_val("after_rst_flush", flush_cnt, 16'd0);
    edge_();

    // stall counter saturation
    do_reset();
    drive(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 65534; k++) begin half(); edge_(); end
    check_val("sat_pre", stall_cnt, 16'hFFFE);
    half(); edge_();
    check_val("sat_hit", stall_cnt, 16'hFFFF);
    for (int k = 0; k < 4465; k++) begin half(); edge_(); end
    check_val("sat_hold", stall_cnt, 16'hFFFF);
    check_val("sat_flush", flush_cnt, 16'd0);

    // randomized against the reference model
    mode = M_RUN; ms = 0; mf = 0;
    for (int c = 0; c < 3000; c++) begin
      v.rst     = (c == 0) || ($urandom_range(0, 39) == 0);
      v.ihit    = ($urandom_range(0, 3) != 0);
      v.dhit    = ($urandom_range(0, 1) != 0);
      v.ren     = ($urandom_range(0, 3) == 0);
      v.wen     = ($urandom_range(0, 3) == 0);
      v.pcsrc   = ($urandom_range(0, 4) == 0);
      v.memread = ($urandom_range(0, 2) == 0);
      v.rt      = 5'($urandom_range(0, 3));
      v.rs      = 5'($urandom_range(0, 3));
      v.rt2     = 5'($urandom_range(0, 3));
      v.idh     = ($urandom_range(0, 14) == 0);
      v.wbh     = ($urandom_range(0, 4) == 0);
      drive(v);
      exp = model_out(v, mode);
      half();
      check_out("rand_out", exp);
      edge_();
      dw = (v.ren | v.wen) & ~v.dhit;
      if (v.rst) begin
        mode = M_RUN; ms = 0; mf = 0;
      end else if (mode != M_HALT) begin
        if (!exp.pc && ms < 65535) ms++;
        if (mode == M_RUN && v.pcsrc && !dw && mf < 65535) mf++;
        if (mode == M_RUN && v.idh && exp.en[2]) mode = M_DRAIN;
        else if (mode == M_DRAIN && v.wbh && !dw) mode = M_HALT;
      end
      check_val("rand_stall", stall_cnt, 16'(ms));
      check_val("rand_flush", flush_cnt, 16'(mf));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
